// File: rtl/pu_cluster_ctrl.sv
// Slave-PU cluster controller: decodes master-core commands into per-PU
// enable/start/run/timeout state and merges completions into one prioritised irq.
module pu_cluster_ctrl #(
  parameter int NUM_PU = 7,
  parameter int DATA_W = 8,
  parameter int SEG_W  = 8,
  parameter int TO_W   = 16,
  parameter int IDX_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [IDX_W-1:0]  cmd_pu,
  input  logic [1:0]        cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_err,
  output logic [NUM_PU-1:0] pu_en,
  output logic [NUM_PU-1:0] pu_start,
  output logic [SEG_W-1:0]  pu_sa,
  output logic [SEG_W-1:0]  pu_sb,
  output logic [SEG_W-1:0]  pu_sc,
  output logic [DATA_W-1:0] pu_ip,
  input  logic [NUM_PU-1:0] pu_int,
  output logic [NUM_PU-1:0] pu_run,
  output logic [NUM_PU-1:0] pu_tmo,
  output logic              irq,
  output logic [IDX_W-1:0]  irq_id
);

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_ENABLE  = 3'd1,
    OP_DISABLE = 3'd2,
    OP_START   = 3'd3,
    OP_CLRINT  = 3'd4,
    OP_SETTO   = 3'd5,
    OP_DESC    = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  localparam logic [IDX_W-1:0] NUM_PU_I = IDX_W'(NUM_PU);

  function automatic logic [SEG_W-1:0] fit_seg(input logic [DATA_W-1:0] v);
    fit_seg = SEG_W'(v);
  endfunction

  function automatic logic [TO_W-1:0] fit_to(input logic [DATA_W-1:0] v);
    fit_to = TO_W'(v);
  endfunction

  function automatic logic [IDX_W-1:0] first_set(input logic [NUM_PU-1:0] v);
    first_set = '0;
    for (int i = NUM_PU - 1; i >= 0; i--) begin
      if (v[i]) first_set = IDX_W'(i);
    end
  endfunction

  // Per-PU state
  logic [NUM_PU-1:0] en_q, run_q, pend_q, tmo_q;
  logic [NUM_PU-1:0] en_n, run_n, pend_n, tmo_n;
  logic [TO_W-1:0]   cnt_q [NUM_PU];
  logic [TO_W-1:0]   cnt_n [NUM_PU];

  // pu_int sample (_p0) and its previous sample (_p1) for edge detection
  logic [NUM_PU-1:0] int_p0, int_p1;

  // Shared staging descriptor and timeout reload
  logic [SEG_W-1:0]  stg_sa, stg_sb, stg_sc;
  logic [SEG_W-1:0]  stg_sa_n, stg_sb_n, stg_sc_n;
  logic [DATA_W-1:0] stg_ip, stg_ip_n;
  logic [TO_W-1:0]   tov_q, tov_n;

  op_e               op;
  logic              pu_cmd;
  logic              pu_ok;
  logic              err_n;
  logic [NUM_PU-1:0] hit;
  logic [NUM_PU-1:0] start_ok;
  logic [NUM_PU-1:0] edge_ev;

  // Command decode
  always_comb begin
    op       = op_e'(cmd_op);
    pu_cmd   = cmd_valid && (op inside {OP_ENABLE, OP_DISABLE, OP_START, OP_CLRINT});
    pu_ok    = (cmd_pu < NUM_PU_I);
    hit      = '0;
    for (int i = 0; i < NUM_PU; i++) begin
      hit[i] = pu_cmd && (cmd_pu == IDX_W'(i));
    end
    start_ok = hit & en_q & ~run_q & {NUM_PU{op == OP_START}};
    err_n    = pu_cmd && (!pu_ok || ((op == OP_START) && (start_ok == '0)));
    edge_ev  = int_p0 & ~int_p1;
  end

  // Per-PU next state; the if/else chain encodes DISABLE > START > completion > timeout.
  // CLRINT is applied first so a same-cycle completion or timeout re-sets pend.
  always_comb begin
    en_n   = en_q;
    run_n  = run_q;
    pend_n = pend_q;
    tmo_n  = tmo_q;
    cnt_n  = cnt_q;
    for (int i = 0; i < NUM_PU; i++) begin
      if (hit[i] && (op == OP_CLRINT)) begin
        pend_n[i] = 1'b0;
        tmo_n[i]  = 1'b0;
      end
      if (hit[i] && (op == OP_ENABLE)) en_n[i] = 1'b1;

      if (hit[i] && (op == OP_DISABLE)) begin
        en_n[i]  = 1'b0;
        run_n[i] = 1'b0;
        cnt_n[i] = '0;
      end else if (start_ok[i]) begin
        run_n[i] = 1'b1;
        cnt_n[i] = tov_q;
      end else if (run_q[i] && edge_ev[i]) begin
        run_n[i]  = 1'b0;
        pend_n[i] = 1'b1;
      end else if (run_q[i] && (tov_q != '0) && (cnt_q[i] != '0)) begin
        cnt_n[i] = cnt_q[i] - TO_W'(1);
        if (cnt_q[i] == TO_W'(1)) begin
          run_n[i]  = 1'b0;
          tmo_n[i]  = 1'b1;
          pend_n[i] = 1'b1;
        end
      end
    end
  end

  // Staging descriptor and timeout reload writes
  always_comb begin
    stg_sa_n = stg_sa;
    stg_sb_n = stg_sb;
    stg_sc_n = stg_sc;
    stg_ip_n = stg_ip;
    tov_n    = tov_q;
    if (cmd_valid && (op == OP_DESC)) begin
      case (cmd_sel)
        2'd0:    stg_sa_n = fit_seg(cmd_data);
        2'd1:    stg_sb_n = fit_seg(cmd_data);
        2'd2:    stg_sc_n = fit_seg(cmd_data);
        default: stg_ip_n = cmd_data;
      endcase
    end
    if (cmd_valid && (op == OP_SETTO)) tov_n = fit_to(cmd_data);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      en_q     <= '0;
      run_q    <= '0;
      pend_q   <= '0;
      tmo_q    <= '0;
      for (int i = 0; i < NUM_PU; i++) cnt_q[i] <= '0;
      int_p0   <= '0;
      int_p1   <= '0;
      stg_sa   <= '0;
      stg_sb   <= '0;
      stg_sc   <= '0;
      stg_ip   <= '0;
      tov_q    <= '0;
      pu_start <= '0;
      cmd_err  <= 1'b0;
      pu_sa    <= '0;
      pu_sb    <= '0;
      pu_sc    <= '0;
      pu_ip    <= '0;
      irq      <= 1'b0;
      irq_id   <= '0;
    end else begin
      en_q     <= en_n;
      run_q    <= run_n;
      pend_q   <= pend_n;
      tmo_q    <= tmo_n;
      cnt_q    <= cnt_n;
      int_p0   <= pu_int;
      int_p1   <= int_p0;
      stg_sa   <= stg_sa_n;
      stg_sb   <= stg_sb_n;
      stg_sc   <= stg_sc_n;
      stg_ip   <= stg_ip_n;
      tov_q    <= tov_n;
      pu_start <= start_ok;
      cmd_err  <= err_n;
      if (|start_ok) begin
        pu_sa <= stg_sa;
        pu_sb <= stg_sb;
        pu_sc <= stg_sc;
        pu_ip <= stg_ip;
      end
      irq      <= |pend_n;
      irq_id   <= first_set(pend_n);
    end
  end

  assign pu_en  = en_q;
  assign pu_run = run_q;
  assign pu_tmo = tmo_q;

endmodule

// File: tb/tb_pu_cluster_ctrl.sv
// Bench for pu_cluster_ctrl: directed scenarios followed by random commands,
// all checked every cycle against a deadline-based reference model.
module tb_pu_cluster_ctrl;
  localparam int NUM_PU = 7;
  localparam int DATA_W = 8;
  localparam int SEG_W  = 8;
  localparam int TO_W   = 16;
  localparam int IDX_W  = 4;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [2:0]        cmd_op = '0;
  logic [IDX_W-1:0]  cmd_pu = '0;
  logic [1:0]        cmd_sel = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_err;
  logic [NUM_PU-1:0] pu_en, pu_start, pu_run, pu_tmo;
  logic [NUM_PU-1:0] pu_int = '0;
  logic [SEG_W-1:0]  pu_sa, pu_sb, pu_sc;
  logic [DATA_W-1:0] pu_ip;
  logic              irq;
  logic [IDX_W-1:0]  irq_id;

  int tests = 0;
  int fails = 0;

  pu_cluster_ctrl #(
    .NUM_PU(NUM_PU), .DATA_W(DATA_W), .SEG_W(SEG_W), .TO_W(TO_W), .IDX_W(IDX_W)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_pu(cmd_pu),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data), .cmd_err(cmd_err),
    .pu_en(pu_en), .pu_start(pu_start),
    .pu_sa(pu_sa), .pu_sb(pu_sb), .pu_sc(pu_sc), .pu_ip(pu_ip),
    .pu_int(pu_int), .pu_run(pu_run), .pu_tmo(pu_tmo),
    .irq(irq), .irq_id(irq_id)
  );

  always #5 CLK = ~CLK;

  // Reference model: flags per PU, absolute timeout deadline in cycles
  bit m_en [NUM_PU];
  bit m_run [NUM_PU];
  bit m_pend [NUM_PU];
  bit m_tmo [NUM_PU];
  int m_dl [NUM_PU];
  int m_stage [4];
  int m_desc [4];
  int m_tov;
  int cyc;
  bit m_err;
  logic [NUM_PU-1:0] m_start;
  logic [NUM_PU-1:0] drv1, drv2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_PU; i++) begin
      m_en[i] = 0; m_run[i] = 0; m_pend[i] = 0; m_tmo[i] = 0; m_dl[i] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      m_stage[k] = 0; m_desc[k] = 0;
    end
    m_tov = 0; m_err = 0; m_start = '0; drv1 = '0; drv2 = '0;
  endtask

  // A pu_int rise seen by the model this cycle is one driven the cycle before
  task automatic model_step(input bit v, input int op, input int pu, input int sel, input int data);
    logic [NUM_PU-1:0] ev;
    bit pu_cmd;
    bit hit;
    ev = drv1 & ~drv2;
    cyc++;
    pu_cmd = v && (op >= 1) && (op <= 4);
    m_err = 0;
    m_start = '0;
    if (pu_cmd && (pu >= NUM_PU)) m_err = 1;
    else if (pu_cmd && op == 3 && !(m_en[pu] && !m_run[pu])) m_err = 1;
    for (int i = 0; i < NUM_PU; i++) begin
      hit = pu_cmd && (pu == i);
      if (hit && op == 4) begin m_pend[i] = 0; m_tmo[i] = 0; end
      if (hit && op == 2) begin
        m_en[i] = 0; m_run[i] = 0;
      end else if (hit && op == 3 && m_en[i] && !m_run[i]) begin
        m_run[i] = 1; m_dl[i] = cyc + m_tov; m_start[i] = 1'b1;
        for (int k = 0; k < 4; k++) m_desc[k] = m_stage[k];
      end else if (m_run[i] && ev[i]) begin
        m_run[i] = 0; m_pend[i] = 1;
      end else if (m_run[i] && m_tov != 0 && cyc == m_dl[i]) begin
        m_run[i] = 0; m_tmo[i] = 1; m_pend[i] = 1;
      end
      if (hit && op == 1) m_en[i] = 1;
    end
    if (v && op == 6) m_stage[sel] = data;
    if (v && op == 5) m_tov = data;
    drv2 = drv1;
    drv1 = pu_int;
  endtask

  task automatic check_model();
    logic [NUM_PU-1:0] e_en, e_run, e_pend, e_tmo;
    int e_id;
    e_id = 0;
    for (int i = NUM_PU - 1; i >= 0; i--) begin
      e_en[i] = m_en[i]; e_run[i] = m_run[i]; e_pend[i] = m_pend[i]; e_tmo[i] = m_tmo[i];
      if (m_pend[i]) e_id = i;
    end
    chk("pu_en", 32'(pu_en), 32'(e_en));
    chk("pu_run", 32'(pu_run), 32'(e_run));
    chk("pu_tmo", 32'(pu_tmo), 32'(e_tmo));
    chk("pu_start", 32'(pu_start), 32'(m_start));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
    chk("irq", 32'(irq), 32'(|e_pend));
    chk("irq_id", 32'(irq_id), e_id);
    chk("pu_sa", 32'(pu_sa), m_desc[0]);
    chk("pu_sb", 32'(pu_sb), m_desc[1]);
    chk("pu_sc", 32'(pu_sc), m_desc[2]);
    chk("pu_ip", 32'(pu_ip), m_desc[3]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en"}, 32'(pu_en), 0);
    chk({tag, "_start"}, 32'(pu_start), 0);
    chk({tag, "_run"}, 32'(pu_run), 0);
    chk({tag, "_tmo"}, 32'(pu_tmo), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_irq_id"}, 32'(irq_id), 0);
    chk({tag, "_err"}, 32'(cmd_err), 0);
    chk({tag, "_desc"}, {pu_sa, pu_sb, pu_sc, pu_ip}, 0);
  endtask

  task automatic step(input bit v, input int op, input int pu, input int sel, input int data);
    cmd_valid = v;
    cmd_op    = 3'(op);
    cmd_pu    = IDX_W'(pu);
    cmd_sel   = 2'(sel);
    cmd_data  = DATA_W'(data);
    model_step(v, op, pu, sel, data);
    @(posedge CLK);
    #1;
    check_model();
    cmd_valid = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic cmd(input int op, input int pu);
    step(1, op, pu, 0, 0);
  endtask

  initial begin
    int r, op, pu;
    cyc = 0;
    model_reset();

    // Reset and idle
    repeat (3) @(posedge CLK);
    #1;
    check_zero("rst");
    RESET = 1'b1;
    for (int n = 0; n < 10; n++) idle();
    check_zero("idle");

    // Descriptor, enable, start on PU 2
    step(1, 6, 0, 0, 8'h12);
    step(1, 6, 0, 1, 8'h34);
    step(1, 6, 0, 2, 8'h56);
    step(1, 6, 0, 3, 8'h78);
    cmd(1, 2);
    cmd(3, 2);
    chk("start_onehot", 32'(pu_start), 32'h04);
    chk("desc_out", {pu_sa, pu_sb, pu_sc, pu_ip}, 32'h12345678);
    chk("run2_set", 32'(pu_run[2]), 1);
    idle();
    chk("start_one_cycle", 32'(pu_start), 0);

    // Completion on PU 2 lands one cycle after the sampled rise
    pu_int[2] = 1'b1;
    idle();
    chk("run2_latency", 32'(pu_run[2]), 1);
    idle();
    chk("run2_done", 32'(pu_run[2]), 0);
    chk("irq_done", 32'(irq), 1);
    chk("irq_id_2", 32'(irq_id), 2);
    pu_int[2] = 1'b0;
    cmd(4, 2);
    chk("irq_clr", 32'(irq), 0);

    // Rejected starts
    cmd(3, 2);
    cmd(3, 3);
    chk("err_disabled", 32'(cmd_err), 1);
    chk("err_disabled_nostart", 32'(pu_start), 0);
    cmd(3, 2);
    chk("err_running", 32'(cmd_err), 1);
    cmd(3, 9);
    chk("err_range", 32'(cmd_err), 1);
    chk("err_range_nostart", 32'(pu_start), 0);
    idle();
    chk("err_pulse", 32'(cmd_err), 0);
    cmd(2, 2);

    // Timeout of 5 cycles on PU 0
    step(1, 5, 0, 0, 5);
    cmd(1, 0);
    cmd(3, 0);
    for (int n = 0; n < 4; n++) idle();
    chk("tmo_not_yet", 32'(pu_run[0]), 1);
    idle();
    chk("tmo_flag", 32'(pu_tmo[0]), 1);
    chk("tmo_irq", 32'(irq), 1);
    chk("tmo_run", 32'(pu_run[0]), 0);
    cmd(4, 0);
    chk("tmo_clr", 32'(pu_tmo[0]), 0);

    // Priority encode with PU 4 and PU 1 pending
    cmd(1, 4);
    cmd(1, 1);
    cmd(3, 4);
    cmd(3, 1);
    for (int n = 0; n < 6; n++) idle();
    chk("prio_1", 32'(irq_id), 1);
    cmd(4, 1);
    chk("prio_4", 32'(irq_id), 4);
    cmd(4, 4);
    chk("prio_none", 32'(irq), 0);

    // DISABLE coinciding with a completion edge on PU 0
    step(1, 5, 0, 0, 0);
    cmd(3, 0);
    pu_int[0] = 1'b1;
    idle();
    cmd(2, 0);
    chk("dis_edge_run", 32'(pu_run[0]), 0);
    chk("dis_edge_pend", 32'(irq), 0);
    idle();
    chk("dis_edge_dropped", 32'(irq), 0);
    pu_int[0] = 1'b0;

    // CLRINT coinciding with a completion edge on PU 5
    cmd(1, 5);
    cmd(3, 5);
    pu_int[5] = 1'b1;
    idle();
    cmd(4, 5);
    chk("clr_edge_irq", 32'(irq), 1);
    chk("clr_edge_id", 32'(irq_id), 5);
    pu_int[5] = 1'b0;
    cmd(4, 5);

    // Asynchronous reset mid-run
    cmd(1, 3);
    cmd(3, 3);
    chk("pre_reset_run", 32'(pu_run[3]), 1);
    RESET = 1'b0;
    #1;
    check_zero("async_rst");
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    model_reset();
    idle();
    check_zero("rst_release");

    // Random commands with a fixed non-zero timeout
    step(1, 5, 0, 0, $urandom_range(3, 12));
    for (int n = 0; n < 500; n++) begin
      for (int b = 0; b < NUM_PU; b++) begin
        if ($urandom_range(0, 5) == 0) pu_int[b] = ~pu_int[b];
      end
      r  = $urandom_range(0, 99);
      pu = $urandom_range(0, 8);
      if (r < 10)      op = 0;
      else if (r < 24) op = 1;
      else if (r < 32) op = 2;
      else if (r < 57) op = 3;
      else if (r < 67) op = 4;
      else if (r < 82) op = 6;
      else             op = 7;
      if (op == 0 || op == 7) pu = $urandom_range(0, NUM_PU - 1);
      step(r < 92, op, pu, $urandom_range(0, 3), $urandom_range(0, 255));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
